// File: rtl/pcileech_com_rx_pack.sv
// COM RX packer: narrow RX words -> DW_IN*RATIO words with resync and init inject.
// Optional counters: define PCILEECH_COM_RX_PACK_STATS_EN.
module pcileech_com_rx_pack #(
    parameter int          DW_IN      = 32,
    parameter int          RATIO      = 2,
    parameter logic [31:0] SYNC_WORD  = 32'h66665555,
    parameter int          SYNC_CNT   = 2,
    parameter int          INIT_NUM   = 5,
    parameter int          INIT_DELAY = 16,
    localparam int         DW_OUT     = DW_IN * RATIO,
    localparam int         NI         = (INIT_NUM > 0) ? INIT_NUM : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW_IN-1:0]     din,
    input  logic                 din_valid,
    input  logic [NI*DW_OUT-1:0] init_words,
    output logic [DW_OUT-1:0]    dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 sync_event,
    output logic                 overflow,
    output logic [31:0]          stat_words,
    output logic [15:0]          stat_syncs,
    output logic [15:0]          stat_drops
);

    localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int RW = $clog2(SYNC_CNT + 1);
    localparam int TW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY + 1) : 1;
    localparam int XW = (NI > 1) ? $clog2(NI) : 1;

    localparam logic [DW_IN-1:0] SYNC_W    = DW_IN'(SYNC_WORD);
    localparam logic [LW-1:0]    LANE_LAST = LW'(RATIO - 1);
    localparam logic [RW-1:0]    RUN_LAST  = RW'(SYNC_CNT - 1);
    localparam logic [TW-1:0]    TICK_LAST = TW'(INIT_DELAY - 1);
    localparam logic [XW-1:0]    IDX_LAST  = XW'(NI - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_INIT,
        S_RUN
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_tick;
    logic [XW-1:0]       r_idx;
    logic [LW-1:0]       r_lane;
    logic [RW-1:0]       r_run;
    logic [DW_OUT-1:0]   r_acc;
    logic [DW_OUT-1:0]   r_buf0;
    logic [DW_OUT-1:0]   r_buf1;
    logic [1:0]          r_cnt;
    logic                r_sync;
    logic                r_ovf;

    logic                w_run_in;
    logic                w_match;
    logic                w_sync_hit;
    logic [DW_OUT-1:0]   w_word;
    logic                w_data_push;
    logic                w_init_push;
    logic                w_push;
    logic [DW_OUT-1:0]   w_pdata;
    logic                w_full;
    logic                w_pop;
    logic                w_space;
    logic                w_drop;
    logic [DW_OUT-1:0]   w_init [NI];

    for (genvar k = 0; k < NI; k++) begin : g_init
        assign w_init[k] = init_words[k*DW_OUT +: DW_OUT];
    end

    assign dout_valid  = (r_cnt != 2'd0);
    assign dout        = r_buf0;
    assign sync_event  = r_sync;
    assign overflow    = r_ovf;

    assign w_pop       = dout_valid & dout_ready;
    assign w_full      = (r_cnt == 2'd2);
    assign w_space     = ~w_full | w_pop;

    assign w_run_in    = (r_state == S_RUN) & din_valid;
    assign w_match     = (din == SYNC_W);
    assign w_sync_hit  = w_run_in & w_match & (r_run == RUN_LAST);
    assign w_word      = (r_acc << DW_IN) | DW_OUT'(din);
    assign w_data_push = w_run_in & ~w_sync_hit & (r_lane == LANE_LAST);

    // Init words wait for room, so they can never be dropped.
    assign w_init_push = (r_state == S_INIT) & w_space;
    assign w_push      = w_init_push | w_data_push;
    assign w_pdata     = (r_state == S_INIT) ? w_init[r_idx] : w_word;
    assign w_drop      = w_data_push & w_full & ~w_pop;

    // Start-up sequencing: delay, then inject init words, then run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_tick  <= '0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                S_WAIT: begin
                    if (r_tick == TICK_LAST) begin
                        r_state <= (INIT_NUM == 0) ? S_RUN : S_INIT;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_INIT: begin
                    if (w_init_push) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_RUN;
                        end else begin
                            r_idx <= r_idx + XW'(1);
                        end
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

    // Lane packing and sync-run tracking; a resync drops the partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_lane <= '0;
            r_run  <= '0;
            r_sync <= 1'b0;
        end else begin
            r_sync <= w_sync_hit;
            if (w_run_in) begin
                if (w_sync_hit) begin
                    r_lane <= '0;
                    r_run  <= '0;
                end else begin
                    r_acc  <= w_word;
                    r_lane <= (r_lane == LANE_LAST) ? '0 : r_lane + LW'(1);
                    r_run  <= w_match ? r_run + RW'(1) : '0;
                end
            end
        end
    end

    // Two-entry output buffer; r_buf0 is the head and drives dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
            r_cnt  <= 2'd0;
            r_ovf  <= 1'b0;
        end else begin
            unique case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_buf0 <= w_pdata;
                        r_cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_buf0 <= w_pdata;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end else if (w_push) begin
                        r_buf1 <= w_pdata;
                        r_cnt  <= 2'd2;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_buf0 <= r_buf1;
                        if (w_push) begin
                            r_buf1 <= w_pdata;
                        end else begin
                            r_cnt <= 2'd1;
                        end
                    end
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef PCILEECH_COM_RX_PACK_STATS_EN
    logic [31:0] r_st_words;
    logic [15:0] r_st_syncs;
    logic [15:0] r_st_drops;

    assign stat_words = r_st_words;
    assign stat_syncs = r_st_syncs;
    assign stat_drops = r_st_drops;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_words <= '0;
            r_st_syncs <= '0;
            r_st_drops <= '0;
        end else begin
            if (w_pop && (r_st_words != '1)) begin
                r_st_words <= r_st_words + 32'd1;
            end
            if (w_sync_hit && (r_st_syncs != '1)) begin
                r_st_syncs <= r_st_syncs + 16'd1;
            end
            if (w_drop && (r_st_drops != '1)) begin
                r_st_drops <= r_st_drops + 16'd1;
            end
        end
    end
`else
    assign stat_words = 32'd0;
    assign stat_syncs = 16'd0;
    assign stat_drops = 16'd0;
`endif

endmodule

// File: tb/tb_pcileech_com_rx_pack.sv
// Bench for pcileech_com_rx_pack: vector table, corner sequences, random vs queue model.
// Stats expectations follow PCILEECH_COM_RX_PACK_STATS_EN.
module tb_pcileech_com_rx_pack;

    localparam int          INIT_DELAY = 16;
    localparam int          INIT_NUM   = 5;
    localparam int          SYNC_CNT   = 2;
    localparam int          RATIO      = 2;
    localparam logic [31:0] SYNC       = 32'h66665555;

    logic                clk;
    logic                rst_n;
    logic [31:0]         din;
    logic                din_valid;
    logic [5*64-1:0]     init_words;
    logic [63:0]         dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                sync_event;
    logic                overflow;
    logic [31:0]         stat_words;
    logic [15:0]         stat_syncs;
    logic [15:0]         stat_drops;

    logic [7:0]          d8_din;
    logic                d8_dv;
    logic [31:0]         d8_init;
    logic [31:0]         d8_dout;
    logic                d8_valid;
    logic                d8_ready;
    logic                d8_sync;
    logic                d8_ovf;
    logic [31:0]         d8_sw;
    logic [15:0]         d8_ss;
    logic [15:0]         d8_sd;

    int nchk;
    int nerr;

    logic [63:0] init_k [5];

    pcileech_com_rx_pack #(
        .DW_IN(32), .RATIO(RATIO), .SYNC_WORD(SYNC), .SYNC_CNT(SYNC_CNT),
        .INIT_NUM(INIT_NUM), .INIT_DELAY(INIT_DELAY)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .init_words(init_words), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .sync_event(sync_event), .overflow(overflow),
        .stat_words(stat_words), .stat_syncs(stat_syncs), .stat_drops(stat_drops)
    );

    pcileech_com_rx_pack #(
        .DW_IN(8), .RATIO(4), .SYNC_WORD(SYNC), .SYNC_CNT(3),
        .INIT_NUM(0), .INIT_DELAY(4)
    ) u_dut8 (
        .clk(clk), .rst_n(rst_n), .din(d8_din), .din_valid(d8_dv),
        .init_words(d8_init), .dout(d8_dout), .dout_valid(d8_valid),
        .dout_ready(d8_ready), .sync_event(d8_sync), .overflow(d8_ovf),
        .stat_words(d8_sw), .stat_syncs(d8_ss), .stat_drops(d8_sd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: output queue, pending lane words, counters.
    logic [63:0] mq [$];
    logic [31:0] mpend [$];
    int          me;
    int          msent;
    int          mrun;
    logic        msync;
    logic        movf;
    int          mw;
    int          ms;
    int          md;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpend.delete();
        me    = 0;
        msent = 0;
        mrun  = 0;
        msync = 1'b0;
        movf  = 1'b0;
        mw    = 0;
        ms    = 0;
        md    = 0;
    endtask

    task automatic model_step();
        logic        pop;
        logic        push;
        logic        hit;
        logic [63:0] pw;
        if (!rst_n) return;
        me++;
        pop  = (mq.size() > 0) && dout_ready;
        push = 1'b0;
        hit  = 1'b0;
        pw   = 64'd0;
        if (me > INIT_DELAY) begin
            if (msent < INIT_NUM) begin
                if (mq.size() < 2 || pop) begin
                    push = 1'b1;
                    pw   = init_k[msent];
                    msent++;
                end
            end else if (din_valid) begin
                if (din == SYNC) begin
                    mrun++;
                    if (mrun == SYNC_CNT) begin
                        hit  = 1'b1;
                        mrun = 0;
                        mpend.delete();
                    end
                end else begin
                    mrun = 0;
                end
                if (!hit) begin
                    mpend.push_back(din);
                    if (mpend.size() == RATIO) begin
                        foreach (mpend[i]) pw = (pw << 32) | 64'(mpend[i]);
                        mpend.delete();
                        push = 1'b1;
                    end
                end
            end
        end
        if (pop) begin
            void'(mq.pop_front());
            mw++;
        end
        if (push) begin
            if (mq.size() < 2) begin
                mq.push_back(pw);
            end else begin
                movf = 1'b1;
                md++;
            end
        end
        msync = hit;
        if (hit) ms++;
    endtask

    task automatic model_check();
        int ew;
        int es;
        int ed;
`ifdef PCILEECH_COM_RX_PACK_STATS_EN
        ew = mw;
        es = ms;
        ed = md;
`else
        ew = 0;
        es = 0;
        ed = 0;
`endif
        chk("m_valid", dout_valid, mq.size() != 0);
        if (mq.size() != 0) chk("m_dout", dout, mq[0]);
        chk("m_sync", sync_event, msync);
        chk("m_ovf", overflow, movf);
        chk("m_stw", stat_words, ew);
        chk("m_sts", stat_syncs, es);
        chk("m_std", stat_drops, ed);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic init_seq();
        for (int i = 1; i <= INIT_DELAY; i++) begin
            cyc();
            chk("init_wait_valid", dout_valid, 1'b0);
        end
        for (int k = 0; k < INIT_NUM; k++) begin
            cyc();
            chk("init_valid", dout_valid, 1'b1);
            chk("init_word", dout, init_k[k]);
        end
        cyc();
        chk("init_done_valid", dout_valid, 1'b0);
    endtask

    typedef struct {
        logic        dv;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [63:0] ed;
        logic        es;
    } vec_t;

    vec_t vec [25];

    logic [63:0] got [5];
    int          ngot;

    initial begin
        nchk = 0;
        nerr = 0;

        vec[0]  = '{1'b1, 32'h11111111, 1'b1, 1'b0, 64'h0, 1'b0};
        vec[1]  = '{1'b1, 32'h22222222, 1'b1, 1'b1, 64'h11111111_22222222, 1'b0};
        vec[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0};
        vec[3]  = '{1'b1, 32'hAAAAAAAA, 1'b1, 1'b0, 64'h0, 1'b0};
        vec[4]  = '{1'b1, SYNC,         1'b1, 1'b1, 64'hAAAAAAAA_66665555, 1'b0};
        vec[5]  = '{1'b1, SYNC,         1'b1, 1'b0, 64'h0, 1'b1};
        vec[6]  = '{1'b1, 32'h33333333, 1'b1, 1'b0, 64'h0, 1'b0};
        vec[7]  = '{1'b1, 32'h44444444, 1'b1, 1'b1, 64'h33333333_44444444, 1'b0};
        vec[8]  = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0};
        vec[9]  = '{1'b1, SYNC,         1'b1, 1'b0, 64'h0, 1'b0};
        vec[10] = '{1'b1, SYNC,         1'b1, 1'b0, 64'h0, 1'b1};
        vec[11] = '{1'b1, 32'h55555555, 1'b1, 1'b0, 64'h0, 1'b0};
        vec[12] = '{1'b1, 32'h77777777, 1'b1, 1'b1, 64'h55555555_77777777, 1'b0};
        vec[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0};
        vec[14] = '{1'b1, SYNC,         1'b1, 1'b0, 64'h0, 1'b0};
        vec[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0};
        vec[16] = '{1'b1, SYNC,         1'b1, 1'b0, 64'h0, 1'b1};
        vec[17] = '{1'b1, 32'h12345678, 1'b1, 1'b0, 64'h0, 1'b0};
        vec[18] = '{1'b1, 32'h9ABCDEF0, 1'b1, 1'b1, 64'h12345678_9ABCDEF0, 1'b0};
        vec[19] = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0};
        vec[20] = '{1'b1, SYNC,         1'b1, 1'b0, 64'h0, 1'b0};
        vec[21] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 64'h66665555_DEADBEEF, 1'b0};
        vec[22] = '{1'b1, SYNC,         1'b1, 1'b0, 64'h0, 1'b0};
        vec[23] = '{1'b1, SYNC,         1'b1, 1'b0, 64'h0, 1'b1};
        vec[24] = '{1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0};

        for (int k = 0; k < 5; k++) begin
            init_k[k] = {32'hC0DE0000 + 32'(k), 32'h600D0000 + 32'(k * 3)};
            init_words[k*64 +: 64] = init_k[k];
        end

        rst_n      = 1'b0;
        din        = 32'd0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        d8_din     = 8'd0;
        d8_dv      = 1'b0;
        d8_init    = 32'd0;
        d8_ready   = 1'b1;
        model_reset();
        cyc();
        cyc();
        chk("rst_dout", dout, 64'd0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_d8_valid", d8_valid, 1'b0);
        chk("rst_d8_dout", d8_dout, 32'd0);
        chk("rst_d8_misc", {d8_sync, d8_ovf, d8_sw, d8_ss, d8_sd}, 0);

        rst_n = 1'b1;
        init_seq();

        for (int i = 0; i < 25; i++) begin
            din_valid  = vec[i].dv;
            din        = vec[i].d;
            dout_ready = vec[i].rdy;
            cyc();
            chk($sformatf("vec%0d_valid", i), dout_valid, vec[i].ev);
            if (vec[i].ev) chk($sformatf("vec%0d_dout", i), dout, vec[i].ed);
            chk($sformatf("vec%0d_sync", i), sync_event, vec[i].es);
        end
`ifdef PCILEECH_COM_RX_PACK_STATS_EN
        chk("tbl_stat_syncs", stat_syncs, 16'd4);
`endif

        dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din_valid = 1'b1;
            din       = 32'h0F000000 + 32'(i);
            cyc();
        end
        din_valid = 1'b0;
        chk("ovf_valid", dout_valid, 1'b1);
        chk("ovf_head", dout, 64'h0F000000_0F000001);
        chk("ovf_flag", overflow, 1'b1);
`ifdef PCILEECH_COM_RX_PACK_STATS_EN
        chk("ovf_stat_drops", stat_drops, 16'd1);
`endif
        dout_ready = 1'b1;
        ngot = 0;
        for (int i = 0; i < 5; i++) begin
            if (dout_valid) begin
                got[ngot] = dout;
                ngot++;
            end
            cyc();
        end
        chk("drain_count", ngot, 2);
        chk("drain_w0", got[0], 64'h0F000000_0F000001);
        chk("drain_w1", got[1], 64'h0F000002_0F000003);

        for (int i = 1; i <= 4; i++) begin
            d8_dv  = 1'b1;
            d8_din = 8'(i);
            cyc();
            chk("d8_valid", d8_valid, i == 4);
        end
        chk("d8_dout", d8_dout, 32'h01020304);
        for (int i = 0; i < 3; i++) begin
            d8_din = 8'h55;
            cyc();
            chk("d8_sync", d8_sync, i == 2);
        end
        for (int i = 1; i <= 4; i++) begin
            d8_din = 8'hA0 + 8'(i);
            cyc();
            chk("d8_sync_after", d8_sync, 1'b0);
        end
        chk("d8_valid2", d8_valid, 1'b1);
        chk("d8_dout2", d8_dout, 32'hA1A2A3A4);
        d8_dv = 1'b0;
        cyc();
        chk("d8_idle", d8_valid, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            din_valid  = ($urandom % 4) != 0;
            din        = (($urandom % 3) == 0) ? SYNC : $urandom;
            dout_ready = ($urandom % 4) != 0;
            cyc();
        end

        din_valid  = 1'b1;
        din        = 32'hBAD0BAD0;
        dout_ready = 1'b1;
        cyc();
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", dout_valid, 1'b0);
        chk("mid_rst_dout", dout, 64'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_stats", {stat_words, stat_syncs, stat_drops}, 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        init_seq();
        din_valid = 1'b1;
        din       = 32'h13572468;
        cyc();
        chk("post_rst_half", dout_valid, 1'b0);
        din = 32'h24681357;
        cyc();
        din_valid = 1'b0;
        chk("post_rst_valid", dout_valid, 1'b1);
        chk("post_rst_dout", dout, 64'h13572468_24681357);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
